// File: rtl/rx_ds_char.sv
// ---------------------------------------------------------------------------
// rx_ds_char
//
// Character assembler for the receive side of a DS link. It takes the bit
// pairs recovered by the data/strobe receiver, hunts for the first NULL
// (ESC followed by FCT) to find character alignment, and then decodes
// control characters, data bytes, NULLs and time codes. Odd parity and
// escape sequences are checked. Every decoded character or error is
// reported as a registered one-cycle pulse.
//
// Ports
//   rxClk        receive clock (DS receiver domain)
//   rxReset      synchronous active-high reset
//   dq[1:0]      recovered bit pair, dq[1] is the earlier bit on the wire
//   dqValid      dq carries a new pair this cycle
//   dqParity     receiver parity indication, unused here
//   synced       high from the first NULL until an error or reset
//   gotNull      NULL received
//   gotFct       FCT received
//   gotEop       EOP received
//   gotEep       EEP received
//   gotData      data byte received, rxData valid
//   rxData[7:0]  last received data byte (held between pulses)
//   gotTime      time code received, timeCode valid
//   timeCode[7:0] last received time code (held between pulses)
//   parityError  parity check failed on a character header
//   escError     ESC followed by anything other than FCT or a data char
// ---------------------------------------------------------------------------
module rx_ds_char (
    input  logic       rxClk,
    input  logic       rxReset,
    input  logic [1:0] dq,
    input  logic       dqValid,
    input  logic       dqParity,
    output logic       synced,
    output logic       gotNull,
    output logic       gotFct,
    output logic       gotEop,
    output logic       gotEep,
    output logic       gotData,
    output logic [7:0] rxData,
    output logic       gotTime,
    output logic [7:0] timeCode,
    output logic       parityError,
    output logic       escError
);

    typedef enum logic [1:0] {
        HUNT,
        HEAD,
        CTRL,
        DATA
    } state_t;

    // NULL as seen on the wire, oldest bit first: x,1,1,1,0,1,0,0.
    // The leading x is the ESC parity bit, which depends on history.
    localparam logic [7:0] NULL_PAT  = 8'b0111_0100;
    localparam logic [7:0] NULL_MASK = 8'b0111_1111;

    state_t     state_q;
    logic       synced_q;
    logic       slip_q;
    logic       lastBit_q;
    logic       prevPar_q;
    logic       escPend_q;
    logic [1:0] cnt_q;
    logic [7:0] hist_q;
    logic [7:0] shift_q;
    logic [7:0] rxData_q;
    logic [7:0] timeCode_q;
    logic       gotNull_q;
    logic       gotFct_q;
    logic       gotEop_q;
    logic       gotEep_q;
    logic       gotData_q;
    logic       gotTime_q;
    logic       parityError_q;
    logic       escError_q;

    logic [1:0] pair_d;
    logic [7:0] histNext_d;
    logic [7:0] histSlip_d;
    logic [7:0] shiftNext_d;
    logic       matchAligned;
    logic       matchSlip;
    logic       headParOk;
    logic       unusedParity;

    assign unusedParity = dqParity;

    // When characters start on dq[0], a character pair straddles two
    // receiver pairs: the held dq[0] of the previous valid pair followed by
    // dq[1] of the current one. Data bits arrive LSB first, so each pair is
    // shifted in from the top with the earlier bit landing lower.
    always_comb begin
        pair_d       = slip_q ? {lastBit_q, dq[1]} : dq;
        histNext_d   = {hist_q[5:0], dq};
        histSlip_d   = {hist_q[6:0], dq[1]};
        shiftNext_d  = {pair_d[0], pair_d[1], shift_q[7:2]};
        matchAligned = ((histNext_d & NULL_MASK) == NULL_PAT);
        matchSlip    = ((histSlip_d & NULL_MASK) == NULL_PAT);
        headParOk    = prevPar_q ^ pair_d[1] ^ pair_d[0];
    end

    // Main decoder. The two alignments of the NULL pattern cannot match on
    // the same pair (they disagree on the third-newest bit), so slip is
    // simply taken from the misaligned detector on a match. Errors drop
    // back to HUNT with a cleared history so stale bits cannot fake a NULL.
    always_ff @(posedge rxClk) begin
        if (rxReset) begin
            state_q       <= HUNT;
            synced_q      <= 1'b0;
            slip_q        <= 1'b0;
            lastBit_q     <= 1'b0;
            prevPar_q     <= 1'b0;
            escPend_q     <= 1'b0;
            cnt_q         <= 2'd0;
            hist_q        <= 8'h00;
            shift_q       <= 8'h00;
            rxData_q      <= 8'h00;
            timeCode_q    <= 8'h00;
            gotNull_q     <= 1'b0;
            gotFct_q      <= 1'b0;
            gotEop_q      <= 1'b0;
            gotEep_q      <= 1'b0;
            gotData_q     <= 1'b0;
            gotTime_q     <= 1'b0;
            parityError_q <= 1'b0;
            escError_q    <= 1'b0;
        end else begin
            gotNull_q     <= 1'b0;
            gotFct_q      <= 1'b0;
            gotEop_q      <= 1'b0;
            gotEep_q      <= 1'b0;
            gotData_q     <= 1'b0;
            gotTime_q     <= 1'b0;
            parityError_q <= 1'b0;
            escError_q    <= 1'b0;
            if (dqValid) begin
                lastBit_q <= dq[0];
                case (state_q)
                    HUNT: begin
                        hist_q <= histNext_d;
                        if (matchAligned || matchSlip) begin
                            slip_q    <= matchSlip;
                            prevPar_q <= 1'b0;
                            escPend_q <= 1'b0;
                            synced_q  <= 1'b1;
                            gotNull_q <= 1'b1;
                            state_q   <= HEAD;
                        end
                    end
                    HEAD: begin
                        if (!headParOk) begin
                            parityError_q <= 1'b1;
                            synced_q      <= 1'b0;
                            escPend_q     <= 1'b0;
                            hist_q        <= 8'h00;
                            state_q       <= HUNT;
                        end else if (pair_d[0]) begin
                            state_q <= CTRL;
                        end else begin
                            cnt_q   <= 2'd0;
                            state_q <= DATA;
                        end
                    end
                    CTRL: begin
                        prevPar_q <= pair_d[1] ^ pair_d[0];
                        state_q   <= HEAD;
                        if (escPend_q) begin
                            if (pair_d == 2'b00) begin
                                gotNull_q <= 1'b1;
                                escPend_q <= 1'b0;
                            end else begin
                                escError_q <= 1'b1;
                                synced_q   <= 1'b0;
                                escPend_q  <= 1'b0;
                                hist_q     <= 8'h00;
                                state_q    <= HUNT;
                            end
                        end else begin
                            case (pair_d)
                                2'b00:   gotFct_q  <= 1'b1;
                                2'b01:   gotEop_q  <= 1'b1;
                                2'b10:   gotEep_q  <= 1'b1;
                                default: escPend_q <= 1'b1;
                            endcase
                        end
                    end
                    DATA: begin
                        shift_q <= shiftNext_d;
                        cnt_q   <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            prevPar_q <= ^shiftNext_d;
                            state_q   <= HEAD;
                            if (escPend_q) begin
                                timeCode_q <= shiftNext_d;
                                gotTime_q  <= 1'b1;
                                escPend_q  <= 1'b0;
                            end else begin
                                rxData_q  <= shiftNext_d;
                                gotData_q <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= HUNT;
                endcase
            end
        end
    end

    assign synced      = synced_q;
    assign gotNull     = gotNull_q;
    assign gotFct      = gotFct_q;
    assign gotEop      = gotEop_q;
    assign gotEep      = gotEep_q;
    assign gotData     = gotData_q;
    assign rxData      = rxData_q;
    assign gotTime     = gotTime_q;
    assign timeCode    = timeCode_q;
    assign parityError = parityError_q;
    assign escError    = escError_q;

endmodule

// File: tb/tb_rx_ds_char.sv
// ---------------------------------------------------------------------------
// tb_rx_ds_char
//
// Drives rx_ds_char with directed pair sequences and then with randomly
// generated character streams (random alignment, gaps, errors and a reset).
// A bit-queue decoder inside the bench predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_rx_ds_char;

    logic       rxClk = 1'b0;
    logic       rxReset;
    logic [1:0] dq;
    logic       dqValid;
    logic       dqParity;
    logic       synced;
    logic       gotNull, gotFct, gotEop, gotEep, gotData, gotTime;
    logic       parityError, escError;
    logic [7:0] rxData, timeCode;

    int total = 0;
    int bad   = 0;

    localparam int PNULL = 7;
    localparam int PFCT  = 6;
    localparam int PEOP  = 5;
    localparam int PEEP  = 4;
    localparam int PDATA = 3;
    localparam int PTIME = 2;
    localparam int PPERR = 1;
    localparam int PEERR = 0;

    always #5 rxClk = ~rxClk;

    rx_ds_char dut (
        .rxClk      (rxClk),
        .rxReset    (rxReset),
        .dq         (dq),
        .dqValid    (dqValid),
        .dqParity   (dqParity),
        .synced     (synced),
        .gotNull    (gotNull),
        .gotFct     (gotFct),
        .gotEop     (gotEop),
        .gotEep     (gotEep),
        .gotData    (gotData),
        .rxData     (rxData),
        .gotTime    (gotTime),
        .timeCode   (timeCode),
        .parityError(parityError),
        .escError   (escError)
    );

    // Reference decoder state: received bits kept as plain queues.
    bit         mSynced  = 1'b0;
    bit         mPrevPar = 1'b0;
    bit         mEsc     = 1'b0;
    bit         mHdr     = 1'b0;
    bit         mBits[$];
    bit         mHunt[$];
    bit   [6:0] nullBits = 7'b1110100;
    logic [7:0] ePulse   = 8'h00;
    logic       eSynced  = 1'b0;
    logic [7:0] eData    = 8'h00;
    logic [7:0] eTime    = 8'h00;

    // Pulse counts and last values as observed on the DUT outputs.
    int         dNull = 0, dFct = 0, dEop = 0, dEep = 0;
    int         dData = 0, dTime = 0, dPerr = 0, dEerr = 0;
    logic [7:0] dLastData = 8'h00;
    logic [7:0] dLastTime = 8'h00;

    // Stimulus state.
    bit         txq[$];
    logic [1:0] seq[$];
    bit         genPrev = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit huntBit(input int k);
        if (k < mHunt.size()) return mHunt[mHunt.size() - 1 - k];
        return 1'b0;
    endfunction

    task automatic modelError(input int idx);
        ePulse[idx] = 1'b1;
        mSynced = 1'b0;
        mEsc    = 1'b0;
        mHdr    = 1'b0;
        mBits.delete();
        mHunt.delete();
    endtask

    task automatic decodeChar(input int len);
        logic [7:0] v;
        logic [1:0] code;
        code = {mBits[2], mBits[3]};
        v = 8'h00;
        if (len == 10) for (int i = 0; i < 8; i++) v[i] = mBits[2 + i];
        repeat (len) void'(mBits.pop_front());
        mHdr = 1'b0;
        if (len == 4) begin
            mPrevPar = code[1] ^ code[0];
            if (mEsc) begin
                if (code == 2'b00) begin
                    ePulse[PNULL] = 1'b1;
                    mEsc = 1'b0;
                end else begin
                    modelError(PEERR);
                end
            end else begin
                case (code)
                    2'b00:   ePulse[PFCT] = 1'b1;
                    2'b01:   ePulse[PEOP] = 1'b1;
                    2'b10:   ePulse[PEEP] = 1'b1;
                    default: mEsc = 1'b1;
                endcase
            end
        end else begin
            mPrevPar = ^v;
            if (mEsc) begin
                eTime = v;
                ePulse[PTIME] = 1'b1;
                mEsc = 1'b0;
            end else begin
                eData = v;
                ePulse[PDATA] = 1'b1;
            end
        end
    endtask

    task automatic modelDecode();
        bit done;
        int len;
        done = 1'b0;
        while (!done) begin
            if (mBits.size() < 2) begin
                done = 1'b1;
            end else if (!mHdr) begin
                if ((mPrevPar ^ mBits[0] ^ mBits[1]) != 1'b1) begin
                    modelError(PPERR);
                    done = 1'b1;
                end else begin
                    mHdr = 1'b1;
                end
            end else begin
                len = mBits[1] ? 4 : 10;
                if (mBits.size() < len) done = 1'b1;
                else begin
                    decodeChar(len);
                    if (!mSynced) done = 1'b1;
                end
            end
        end
    endtask

    task automatic modelStep();
        bit al, sl;
        if (rxReset === 1'b1) begin
            mSynced = 1'b0; mPrevPar = 1'b0; mEsc = 1'b0; mHdr = 1'b0;
            mBits.delete();
            mHunt.delete();
            ePulse = 8'h00; eData = 8'h00; eTime = 8'h00;
        end else begin
            ePulse = 8'h00;
            if (dqValid === 1'b1) begin
                if (!mSynced) begin
                    mHunt.push_back(dq[1]);
                    mHunt.push_back(dq[0]);
                    while (mHunt.size() > 16) void'(mHunt.pop_front());
                    al = 1'b1;
                    sl = 1'b1;
                    for (int i = 0; i < 7; i++) begin
                        if (huntBit(6 - i) != nullBits[6 - i]) al = 1'b0;
                        if (huntBit(7 - i) != nullBits[6 - i]) sl = 1'b0;
                    end
                    if (al || sl) begin
                        mSynced = 1'b1; mPrevPar = 1'b0; mEsc = 1'b0; mHdr = 1'b0;
                        mBits.delete();
                        if (sl) mBits.push_back(dq[0]);
                        ePulse[PNULL] = 1'b1;
                    end
                end else begin
                    mBits.push_back(dq[1]);
                    mBits.push_back(dq[0]);
                    modelDecode();
                end
            end
        end
        eSynced = mSynced;
    endtask

    // Single compare process: one model step per clock, then every output
    // is compared against the prediction, just after the active edge.
    always @(posedge rxClk) begin
        #1;
        modelStep();
        checkOutput("pulses", {gotNull, gotFct, gotEop, gotEep, gotData, gotTime, parityError, escError}, ePulse);
        checkOutput("synced", synced, eSynced);
        checkOutput("rxData", rxData, eData);
        checkOutput("timeCode", timeCode, eTime);
        if (gotNull === 1'b1) dNull++;
        if (gotFct === 1'b1) dFct++;
        if (gotEop === 1'b1) dEop++;
        if (gotEep === 1'b1) dEep++;
        if (gotData === 1'b1) begin dData++; dLastData = rxData; end
        if (gotTime === 1'b1) begin dTime++; dLastTime = timeCode; end
        if (parityError === 1'b1) dPerr++;
        if (escError === 1'b1) dEerr++;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge rxClk);
            dqValid  = 1'b0;
            dq       = 2'($urandom_range(0, 3));
            dqParity = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic drivePair(input logic [1:0] p, input int gapPct);
        if ($urandom_range(0, 99) < gapPct) idle($urandom_range(1, 3));
        @(negedge rxClk);
        dq       = p;
        dqValid  = 1'b1;
        dqParity = 1'($urandom_range(0, 1));
    endtask

    task automatic driveSeq(input int gapPct);
        foreach (seq[i]) drivePair(seq[i], gapPct);
        idle(2);
    endtask

    task automatic resetDut();
        @(negedge rxClk);
        rxReset = 1'b1;
        dqValid = 1'($urandom_range(0, 1));
        dq      = 2'($urandom_range(0, 3));
        @(negedge rxClk);
        rxReset = 1'b0;
        dqValid = 1'b0;
    endtask

    task automatic addCtrl(input bit [1:0] code, input bit badPar);
        bit p;
        p = genPrev ^ badPar;
        txq.push_back(p);
        txq.push_back(1'b1);
        txq.push_back(code[1]);
        txq.push_back(code[0]);
        genPrev = code[1] ^ code[0];
    endtask

    task automatic addData(input bit [7:0] v, input bit badPar);
        bit p;
        p = ~genPrev ^ badPar;
        txq.push_back(p);
        txq.push_back(1'b0);
        for (int i = 0; i < 8; i++) txq.push_back(v[i]);
        genPrev = ^v;
    endtask

    task automatic addRandomChar();
        int r;
        r = $urandom_range(0, 15);
        case (r)
            4:       addCtrl(2'b00, 1'b0);
            5:       addCtrl(2'b01, 1'b0);
            6:       addCtrl(2'b10, 1'b0);
            7:       begin addCtrl(2'b11, 1'b0); addCtrl(2'b00, 1'b0); end
            8, 9:    begin addCtrl(2'b11, 1'b0); addData(8'($urandom), 1'b0); end
            10:      begin addCtrl(2'b11, 1'b0); addCtrl(2'($urandom_range(1, 3)), 1'b0); end
            11:      addData(8'($urandom), 1'b1);
            12:      addCtrl(2'($urandom_range(0, 2)), 1'b1);
            default: addData(8'($urandom), 1'b0);
        endcase
    endtask

    task automatic applyStimulus(input int gapPct);
        bit b1, b0;
        while (txq.size() >= 2) begin
            b1 = txq.pop_front();
            b0 = txq.pop_front();
            drivePair({b1, b0}, gapPct);
        end
    endtask

    initial begin
        int n0, n1, n2;
        rxReset  = 1'b1;
        dqValid  = 1'b0;
        dq       = 2'b00;
        dqParity = 1'b0;
        repeat (2) @(negedge rxClk);
        rxReset = 1'b0;
        idle(2);
        checkOutput("reset synced", synced, 0);
        checkOutput("reset rxData", rxData, 8'h00);
        checkOutput("reset timeCode", timeCode, 8'h00);

        // NULL sync from reset
        seq = '{2'b01, 2'b11, 2'b01, 2'b00};
        driveSeq(0);
        checkOutput("null count", dNull, 1);
        checkOutput("null synced", synced, 1);
        checkOutput("null no other pulse", dFct + dEop + dEep + dData + dTime + dPerr + dEerr, 0);

        // data 5A then EOP
        n0 = dData; n1 = dEop;
        seq = '{2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01};
        driveSeq(0);
        checkOutput("data count", dData - n0, 1);
        checkOutput("data value", dLastData, 8'h5A);
        checkOutput("model data value", eData, 8'h5A);
        checkOutput("eop count", dEop - n1, 1);

        // ESC then data 3C gives a time code (parity after EOP is 1)
        n0 = dData; n1 = dTime;
        seq = '{2'b11, 2'b11, 2'b10, 2'b00, 2'b11, 2'b11, 2'b00};
        driveSeq(0);
        checkOutput("time count", dTime - n1, 1);
        checkOutput("time value", dLastTime, 8'h3C);
        checkOutput("model time value", eTime, 8'h3C);
        checkOutput("time no data", dData - n0, 0);

        // ESC then EOP is an escape error
        n0 = dEerr;
        seq = '{2'b01, 2'b11, 2'b01, 2'b01};
        driveSeq(0);
        checkOutput("esc error count", dEerr - n0, 1);
        checkOutput("esc error synced", synced, 0);

        // resync, then a data header with wrong parity, then resync again
        n0 = dNull; n1 = dPerr;
        seq = '{2'b01, 2'b11, 2'b01, 2'b00, 2'b00};
        driveSeq(0);
        checkOutput("parity error count", dPerr - n1, 1);
        checkOutput("parity error synced", synced, 0);
        seq = '{2'b01, 2'b11, 2'b01, 2'b00};
        driveSeq(0);
        checkOutput("resync null count", dNull - n0, 2);
        checkOutput("resync synced", synced, 1);

        // misaligned NULL followed by A5, without and with gaps
        for (int g = 0; g < 2; g++) begin
            resetDut();
            n0 = dNull; n1 = dData; n2 = dPerr + dEerr;
            seq = '{2'b00, 2'b11, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10};
            driveSeq(g * 100);
            checkOutput("slip null count", dNull - n0, 1);
            checkOutput("slip data count", dData - n1, 1);
            checkOutput("slip data value", dLastData, 8'hA5);
            checkOutput("slip no error", dPerr + dEerr - n2, 0);
        end

        // random streams
        resetDut();
        for (int s = 0; s < 60; s++) begin
            repeat ($urandom_range(0, 1)) txq.push_back(1'($urandom_range(0, 1)));
            addCtrl(2'b11, 1'b0);
            addCtrl(2'b00, 1'b0);
            for (int c = 0; c < 8; c++) addRandomChar();
            applyStimulus(($urandom_range(0, 1) == 1) ? 30 : 0);
            if (s == 30) resetDut();
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
